// File: rtl/countdown_timer_bcd_if.sv
// Button-pulse and display bundle for countdown_timer_bcd.
// The slave modport is the timer side. The master modport is the button/display side.
interface countdown_timer_bcd_if;
  // Handshake: there is no valid/ready pairing.
  // The four button inputs are already debounced. Each one is high for exactly one clk cycle
  // and is sampled on the rising edge of clk.
  // Every output is a registered level that updates one edge after the pulse that caused it.
  logic       start_stop;
  logic       clr;
  logic       inc_sec;
  logic       inc_min;
  logic [3:0] H_0_T;
  logic [3:0] H_1_T;
  logic [3:0] H_2_T;
  logic [3:0] H_3_T;
  logic       running;
  logic       alarm;
  logic [1:0] dbg_state;

  modport slave (
    input  start_stop, clr, inc_sec, inc_min,
    output H_0_T, H_1_T, H_2_T, H_3_T, running, alarm, dbg_state
  );

  modport master (
    output start_stop, clr, inc_sec, inc_min,
    input  H_0_T, H_1_T, H_2_T, H_3_T, running, alarm, dbg_state
  );
endinterface

// File: rtl/countdown_timer_bcd.sv
// Settable MM:SS BCD countdown timer with a 1 Hz prescaler and an IDLE/RUN/PAUSE/DONE FSM.
// Defining TIMER_AUTORELOAD_EN makes expiry reload the preset and emit a one-cycle alarm pulse.
module countdown_timer_bcd #(
  parameter int TICK_DIV = 50_000_000,
  parameter int MAX_MIN  = 99
) (
  input  logic                  clk,
  input  logic                  rst_n,
  countdown_timer_bcd_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_U = 4'(MAX_MIN % 10);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Digit packing is {min tens, min units, sec tens, sec units}.
  logic [1:0]    r_state;
  logic [15:0]   r_pre;
  logic [15:0]   r_cnt;
  logic [PW-1:0] r_presc;
  logic          r_running;
  logic          r_alarm;

  logic [1:0]    w_nstate;
  logic [15:0]   w_npre;
  logic [15:0]   w_ncnt;
  logic [PW-1:0] w_npresc;
  logic          w_nalarm;
  logic [15:0]   w_pre_inc;
  logic [15:0]   w_cnt_dec;
  logic          w_tick;
  logic          w_dec_zero;

  function automatic logic [7:0] inc_sec_f(input logic [7:0] v);
    if (v == 8'h59)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_min_f(input logic [7:0] v);
    if (v[7:4] == MAX_T && v[3:0] == MAX_U) return 8'h00;
    else if (v[3:0] == 4'd9)                return {v[7:4] + 4'd1, 4'd0};
    else                                    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // One-second BCD decrement. It is only applied to a non-zero count.
  function automatic logic [15:0] dec_f(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) begin
          r[11:8] = v[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign w_pre_inc  = {bus.inc_min ? inc_min_f(r_pre[15:8]) : r_pre[15:8],
                       bus.inc_sec ? inc_sec_f(r_pre[7:0])  : r_pre[7:0]};
  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_cnt_dec  = dec_f(r_cnt);
  assign w_dec_zero = (w_cnt_dec == 16'h0000);

  always_comb begin
    w_nstate = r_state;
    w_npre   = r_pre;
    w_ncnt   = r_cnt;
    w_npresc = r_presc;
    w_nalarm = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.clr) begin
          w_npre = 16'h0000;
          w_ncnt = 16'h0000;
        end else if (bus.start_stop && r_pre != 16'h0000) begin
          w_nstate = S_RUN;
          w_ncnt   = r_pre;
          w_npresc = '0;
        end else begin
          // A start on a zero preset is ignored, so the increment still lands.
          w_npre = w_pre_inc;
          w_ncnt = w_pre_inc;
        end
      end
      S_RUN: begin
        if (bus.clr) begin
          w_nstate = S_IDLE;
          w_ncnt   = r_pre;
        end else begin
          if (bus.start_stop) w_nstate = S_PAUSE;
          if (w_tick) begin
            w_npresc = '0;
            if (w_dec_zero) begin
`ifdef TIMER_AUTORELOAD_EN
              w_ncnt   = r_pre;
              w_nalarm = 1'b1;
`else
              w_ncnt   = 16'h0000;
              w_nstate = S_DONE;
`endif
            end else begin
              w_ncnt = w_cnt_dec;
            end
          end else begin
            w_npresc = r_presc + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (bus.clr) begin
          w_nstate = S_IDLE;
          w_ncnt   = r_pre;
        end else if (bus.start_stop) begin
          w_nstate = S_RUN;
        end
      end
      default: begin
        if (bus.clr || bus.start_stop) begin
          w_nstate = S_IDLE;
          w_ncnt   = r_pre;
        end
      end
    endcase
`ifndef TIMER_AUTORELOAD_EN
    w_nalarm = (w_nstate == S_DONE);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pre     <= 16'h0000;
      r_cnt     <= 16'h0000;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_pre     <= w_npre;
      r_cnt     <= w_ncnt;
      r_presc   <= w_npresc;
      r_running <= (w_nstate == S_RUN);
      r_alarm   <= w_nalarm;
    end
  end

  assign bus.H_0_T     = r_cnt[3:0];
  assign bus.H_1_T     = r_cnt[7:4];
  assign bus.H_2_T     = r_cnt[11:8];
  assign bus.H_3_T     = r_cnt[15:12];
  assign bus.running   = r_running;
  assign bus.alarm     = r_alarm;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Self-checking bench for countdown_timer_bcd built with TICK_DIV=4 and MAX_MIN=12.
// It uses a fixed vector table, hand-written corner sequences and a randomized run checked against a seconds-based model.
module tb_countdown_timer_bcd;
  localparam int TD = 4;
  localparam int MM = 12;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  countdown_timer_bcd_if bus ();
  countdown_timer_bcd #(.TICK_DIV(TD), .MAX_MIN(MM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] exp_q[$];

  // The model keeps the preset as minutes/seconds and the count as total seconds.
  int m_state, m_pm, m_ps, m_cnt, m_ph;
  bit m_alarm;

  function automatic logic [17:0] ev(int h3, int h2, int h1, int h0, int r, int a);
    return {4'(h3), 4'(h2), 4'(h1), 4'(h0), 1'(r), 1'(a)};
  endfunction

  function automatic logic [17:0] model_vec();
    int s, m;
    s = m_cnt % 60;
    m = m_cnt / 60;
    return ev(m / 10, m % 10, s / 10, s % 10, (m_state == M_RUN) ? 1 : 0, m_alarm ? 1 : 0);
  endfunction

  function automatic logic [17:0] dut_vec();
    return {bus.H_3_T, bus.H_2_T, bus.H_1_T, bus.H_0_T, bus.running, bus.alarm};
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got digits %h run %b alarm %b, want digits %h run %b alarm %b",
               name, act[17:2], act[1], act[0], exp[17:2], exp[1], exp[0]);
    end
  endtask

  task automatic model_update(input bit ss, input bit cl, input bit is, input bit im);
    if (!rst_n) begin
      m_state = M_IDLE; m_pm = 0; m_ps = 0; m_cnt = 0; m_ph = 0; m_alarm = 0;
    end else begin
      m_alarm = 0;
      case (m_state)
        M_IDLE: begin
          if (cl) begin
            m_pm = 0; m_ps = 0;
          end else if (ss && (m_pm * 60 + m_ps) != 0) begin
            m_state = M_RUN; m_ph = 0;
          end else begin
            if (is) m_ps = (m_ps + 1) % 60;
            if (im) m_pm = (m_pm + 1) % (MM + 1);
          end
          m_cnt = m_pm * 60 + m_ps;
        end
        M_RUN: begin
          if (cl) begin
            m_state = M_IDLE; m_cnt = m_pm * 60 + m_ps;
          end else begin
            m_ph++;
            if (m_ph == TD) begin
              m_ph = 0;
              m_cnt--;
              if (m_cnt == 0) begin
`ifdef TIMER_AUTORELOAD_EN
                m_cnt = m_pm * 60 + m_ps;
                m_alarm = 1;
`else
                m_state = M_DONE;
`endif
              end
            end
            if (m_state == M_RUN && ss) m_state = M_PAUSE;
          end
        end
        M_PAUSE: begin
          if (cl) begin
            m_state = M_IDLE; m_cnt = m_pm * 60 + m_ps;
          end else if (ss) begin
            m_state = M_RUN;
          end
        end
        default: begin
          if (cl || ss) begin
            m_state = M_IDLE; m_cnt = m_pm * 60 + m_ps;
          end
        end
      endcase
`ifndef TIMER_AUTORELOAD_EN
      m_alarm = (m_state == M_DONE);
`endif
    end
    exp_q.push_back(model_vec());
  endtask

  task automatic step(input bit ss, input bit cl, input bit is, input bit im);
    logic [17:0] e;
    bus.start_stop = ss; bus.clr = cl; bus.inc_sec = is; bus.inc_min = im;
    @(posedge clk);
    model_update(ss, cl, is, im);
    #1;
    bus.start_stop = 1'b0; bus.clr = 1'b0; bus.inc_sec = 1'b0; bus.inc_min = 1'b0;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL model_queue: got empty queue, want one entry");
    end else begin
      e = exp_q.pop_front();
      check("model", dut_vec(), e);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  typedef struct {
    bit ss, cl, is, im;
    logic [17:0] exp;
  } vec_t;
  vec_t vt[21];

  initial begin
    vt[0]  = '{1, 0, 0, 0, ev(0, 0, 0, 0, 0, 0)};
    vt[1]  = '{0, 0, 1, 0, ev(0, 0, 0, 1, 0, 0)};
    vt[2]  = '{0, 0, 1, 0, ev(0, 0, 0, 2, 0, 0)};
    vt[3]  = '{0, 0, 1, 0, ev(0, 0, 0, 3, 0, 0)};
    vt[4]  = '{0, 0, 0, 1, ev(0, 1, 0, 3, 0, 0)};
    vt[5]  = '{0, 0, 1, 1, ev(0, 2, 0, 4, 0, 0)};
    vt[6]  = '{0, 1, 0, 0, ev(0, 0, 0, 0, 0, 0)};
    vt[7]  = '{0, 0, 0, 1, ev(0, 1, 0, 0, 0, 0)};
    vt[8]  = '{1, 0, 1, 1, ev(0, 1, 0, 0, 1, 0)};
    vt[9]  = '{0, 0, 0, 0, ev(0, 1, 0, 0, 1, 0)};
    vt[10] = '{0, 0, 1, 0, ev(0, 1, 0, 0, 1, 0)};
    vt[11] = '{0, 0, 0, 0, ev(0, 1, 0, 0, 1, 0)};
    vt[12] = '{0, 0, 0, 0, ev(0, 0, 5, 9, 1, 0)};
    vt[13] = '{1, 0, 0, 0, ev(0, 0, 5, 9, 0, 0)};
    vt[14] = '{0, 0, 0, 0, ev(0, 0, 5, 9, 0, 0)};
    vt[15] = '{1, 0, 0, 0, ev(0, 0, 5, 9, 1, 0)};
    vt[16] = '{0, 0, 0, 0, ev(0, 0, 5, 9, 1, 0)};
    vt[17] = '{0, 0, 0, 0, ev(0, 0, 5, 9, 1, 0)};
    vt[18] = '{0, 0, 0, 0, ev(0, 0, 5, 8, 1, 0)};
    vt[19] = '{0, 1, 0, 0, ev(0, 1, 0, 0, 0, 0)};
    vt[20] = '{1, 1, 0, 0, ev(0, 0, 0, 0, 0, 0)};

    bus.start_stop = 1'b0; bus.clr = 1'b0; bus.inc_sec = 1'b0; bus.inc_min = 1'b0;
    rst_n = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    check("reset_state", dut_vec(), ev(0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 21; i++) begin
      step(vt[i].ss, vt[i].cl, vt[i].is, vt[i].im);
      check($sformatf("vec%0d", i), dut_vec(), vt[i].exp);
    end

    // Seconds wrap without carrying into minutes.
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    check("preset_0103", dut_vec(), ev(0, 1, 0, 3, 0, 0));
    for (int i = 0; i < 60; i++) step(0, 0, 1, 0);
    check("sec_wrap", dut_vec(), ev(0, 1, 0, 3, 0, 0));

    // Minutes wrap at MAX_MIN.
    step(0, 1, 0, 0);
    for (int i = 0; i < MM; i++) step(0, 0, 0, 1);
    check("min_max", dut_vec(), ev(1, 2, 0, 0, 0, 0));
    step(0, 0, 0, 1);
    check("min_wrap", dut_vec(), ev(0, 0, 0, 0, 0, 0));

    // Minute and tens borrow.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    idle_steps(4);
    check("first_tick", dut_vec(), ev(0, 0, 5, 9, 1, 0));
    idle_steps(40);
    check("tens_borrow", dut_vec(), ev(0, 0, 4, 9, 1, 0));
    step(0, 1, 0, 0);
    check("clr_run", dut_vec(), ev(0, 1, 0, 0, 0, 0));

`ifndef TIMER_AUTORELOAD_EN
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    idle_steps(4);
    step(1, 0, 0, 0);
    check("paused", dut_vec(), ev(0, 0, 0, 1, 0, 0));
    idle_steps(20);
    check("pause_hold", dut_vec(), ev(0, 0, 0, 1, 0, 0));
    step(1, 0, 0, 0);
    idle_steps(2);
    check("before_done", dut_vec(), ev(0, 0, 0, 1, 1, 0));
    step(0, 0, 0, 0);
    check("done", dut_vec(), ev(0, 0, 0, 0, 0, 1));
    idle_steps(3);
    check("done_hold", dut_vec(), ev(0, 0, 0, 0, 0, 1));
    step(0, 1, 0, 0);
    check("done_clr", dut_vec(), ev(0, 0, 0, 2, 0, 0));
`else
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      idle_steps(3);
      check($sformatf("reload_wait%0d", k), dut_vec(), ev(0, 0, 0, 1, 1, 0));
      step(0, 0, 0, 0);
      check($sformatf("reload_pulse%0d", k), dut_vec(), ev(0, 0, 0, 1, 1, 1));
    end
    step(0, 1, 0, 0);
`endif

    // Clear beats start in RUN. A reset mid-run aborts immediately.
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    idle_steps(2);
    step(1, 1, 0, 0);
    check("ss_clr_run", dut_vec(), ev(0, 1, 0, 0, 0, 0));
    step(1, 0, 0, 0);
    idle_steps(6);
    rst_n = 1'b0;
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    check("reset_mid_run", dut_vec(), ev(0, 0, 0, 0, 0, 0));
    n_cmp++;
    if (bus.dbg_state !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_dbg_state: got %0d, want 0", bus.dbg_state);
    end

    // Randomized pulses checked against the model on every cycle.
    for (int i = 0; i < 3000; i++) begin
      bit ss, cl, is, im;
      ss = ($urandom_range(0, 9) == 0);
      cl = ($urandom_range(0, 29) == 0);
      is = ($urandom_range(0, 3) == 0);
      im = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      step(ss, cl, is, im);
      rst_n = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
- Settable MM:SS countdown timer that produces four BCD digits for the 7-segment display stage (the _T digit inputs of the display mux).
- Built-in clock prescaler divides clk down to a 1 Hz tick; the state machine handles set, run, pause and expiry.
- Raises alarm at 00:00 for the buzzer/LED logic.
- Buttons arrive already debounced as one-cycle pulses.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per one-second tick (>=2).
- MAX_MIN, 99, maximum settable minutes value (1..99).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- start_stop  in  1  one-cycle pulse: start, pause or resume
- clr  in  1  one-cycle pulse: clear or reload
- inc_sec  in  1  one-cycle pulse: increment preset seconds
- inc_min  in  1  one-cycle pulse: increment preset minutes
- H_0_T  out  4  seconds units, BCD 0..9
- H_1_T  out  4  seconds tens, BCD 0..5
- H_2_T  out  4  minutes units, BCD 0..9
- H_3_T  out  4  minutes tens, BCD 0..9
- running  out  1  high while in RUN
- alarm  out  1  high while in DONE

Behaviour:
- Clock: one clock, clk. Reset: synchronous, active-low, port rst_n.
- All outputs are registered. Every response to an input pulse appears on the next rising edge (latency 1).
- Reset state: IDLE. Preset = 00:00, count = 00:00, prescaler = 0, running = 0, alarm = 0. Reset asserted mid-RUN aborts immediately with the same values.
- Internal registers:
  - preset: 4 BCD digits.
  - count: 4 BCD digits, driven onto H_*_T.
  - prescaler: $clog2(TICK_DIV) bits.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - Count mirrors preset.
  - inc_sec: seconds 00→59 then wraps to 00, with no carry into minutes.
  - inc_min: minutes 00→MAX_MIN then wraps to 00.
  - inc_sec and inc_min in the same cycle: both apply.
  - clr: preset = 00:00.
  - start_stop with preset ≠ 00:00: go to RUN, count = preset, prescaler = 0.
  - start_stop with preset = 00:00: ignored, stay in IDLE.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. The tick fires in the cycle where prescaler = TICK_DIV-1, and prescaler then wraps to 0.
  - On tick, count decrements by one second with BCD borrow: x0 → (x-1)9 in the seconds units digit; seconds 00 → 59 with minutes -1; minutes 10 → 09.
  - If the decrement yields 00:00: go to DONE in the same edge. First tick after start lands TICK_DIV cycles after the start edge.
  - start_stop: go to PAUSE. Prescaler holds its value so the sub-second phase is kept.
  - clr: go to IDLE, count = preset.
  - inc_* are ignored.
- PAUSE:
  - Count and prescaler are frozen.
  - start_stop: resume RUN.
  - clr: go to IDLE, count = preset.
- DONE:
  - Count = 00:00, alarm = 1.
  - start_stop or clr: go to IDLE, count = preset, alarm = 0.
- Simultaneous events:
  - clr beats start_stop in every state.
  - A tick in the same cycle as start_stop in RUN: the tick's decrement is applied, then pause.
  - start_stop in the same cycle as inc_* in IDLE: start wins and inc_* is dropped.
- running = 1 exactly when state is RUN.

Optional Feature:
- Macro: TIMER_AUTORELOAD_EN.
- Defined: on reaching 00:00 in RUN, count reloads from preset and the timer stays in RUN (prescaler continues from 0). alarm pulses high for exactly one cycle per expiry. DONE is unreachable.
- Not defined: behaviour is as specified above; alarm is a level held in DONE.

Test Plan:
- TICK_DIV=4, reset → all digits 0, running=0, alarm=0. Then start_stop → stays IDLE, running=0.
- 3× inc_sec, 1× inc_min → H_3..H_0 = 0,1,0,3. Then 60× inc_sec → seconds wrap to 03 with minutes still 01.
- Preset 01:00, start → after 4 cycles reads 00:59. Tens-borrow check: after a further 40 cycles reads 00:49.
- Preset 00:02, start, pause after 5 cycles (count 00:01), hold 20 cycles → count unchanged. Resume → DONE 3 cycles later with alarm=1, running=0. Then clr → IDLE, count 00:02, alarm=0.
- start_stop and clr in the same cycle during RUN → IDLE, count = preset. Reset asserted mid-RUN → IDLE with 00:00 preset.
- With TIMER_AUTORELOAD_EN, preset 00:01, TICK_DIV=4 → alarm pulses once every 4 cycles, count shows 00:01 after each reload, running stays 1.
